// File: rtl/pulse_lvl_pkg.sv
// Shared mode encodings for the pulse/level converter channels.
// Both the channel logic and any integrating code decode mode fields through this enum.
package pulse_lvl_pkg;

   localparam int MODE_W = 2;

   typedef enum logic [MODE_W-1:0] {
      MODE_TOGGLE  = 2'b00,
      MODE_STRETCH = 2'b01,
      MODE_EDGE    = 2'b10,
      MODE_RSVD    = 2'b11
   } mode_e;

endpackage

// File: rtl/pulse_lvl_chan.sv
// One independent pulse/level conversion channel.
// Supports toggle, stretch, edge and reserved modes, with sync clear and mode-change flush.
module pulse_lvl_chan
   import pulse_lvl_pkg::*;
#(
   parameter int STRETCH_W   = 4,
   parameter int STRETCH_LEN = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              d,
   input  logic              clr,
   input  logic [MODE_W-1:0] mode,
   output logic              lvl
);

   localparam logic [STRETCH_W-1:0] LEN_C = STRETCH_W'(STRETCH_LEN);

   logic                 lvl_q, lvl_n;
   logic [STRETCH_W-1:0] cnt_q, cnt_n;
   logic                 prev_d_q;
   mode_e                mode_q, mode_n;

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lvl_q    <= 1'b0;
         cnt_q    <= '0;
         prev_d_q <= 1'b0;
         mode_q   <= MODE_TOGGLE;
      end else begin
         lvl_q    <= lvl_n;
         cnt_q    <= cnt_n;
         prev_d_q <= d;
         mode_q   <= mode_n;
      end
   end

   // NOTE: every signal gets a default first so no path through the case can infer a latch.
   always_comb begin
      mode_n = mode_e'(mode);
      lvl_n  = 1'b0;
      cnt_n  = '0;
      // A clear or a mode change flushes the channel and swallows any event this cycle.
      if (!clr && (mode_n == mode_q)) begin
         unique case (mode_q)
            MODE_TOGGLE: lvl_n = lvl_q ^ d;
            MODE_STRETCH: begin
               if (d)
                  cnt_n = LEN_C;
               else if (cnt_q != '0)
                  cnt_n = cnt_q - STRETCH_W'(1);
               lvl_n = (cnt_n != '0);
            end
            MODE_EDGE: lvl_n = d ^ prev_d_q;
            MODE_RSVD: lvl_n = 1'b0;
         endcase
      end
   end

   assign lvl = lvl_q;

endmodule

// File: rtl/pulse_lvl_conv.sv
// Multi-channel pulse/level converter: CH independent pulse_lvl_chan instances.
// Holds no state itself; only slices the packed buses and validates parameters.
module pulse_lvl_conv
   import pulse_lvl_pkg::*;
#(
   parameter int CH          = 4,
   parameter int STRETCH_W   = 4,
   parameter int STRETCH_LEN = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [CH-1:0]        d,
   input  logic [CH-1:0]        clr,
   input  logic [MODE_W*CH-1:0] mode,
   output logic [CH-1:0]        lvl
);

   if (CH < 1 || CH > 32) begin : g_bad_ch
      $error("pulse_lvl_conv: CH=%0d outside 1..32", CH);
   end
   if (STRETCH_W < 2 || STRETCH_W > 16) begin : g_bad_w
      $error("pulse_lvl_conv: STRETCH_W=%0d outside 2..16", STRETCH_W);
   end
   if (STRETCH_LEN < 1 || STRETCH_LEN > (2 ** STRETCH_W) - 1) begin : g_bad_len
      $error("pulse_lvl_conv: STRETCH_LEN=%0d does not fit STRETCH_W=%0d", STRETCH_LEN, STRETCH_W);
   end

   for (genvar i = 0; i < CH; i++) begin : g_chan
      pulse_lvl_chan #(
         .STRETCH_W   (STRETCH_W),
         .STRETCH_LEN (STRETCH_LEN)
      ) u_chan (
         .clk   (clk),
         .rst_n (rst_n),
         .d     (d[i]),
         .clr   (clr[i]),
         .mode  (mode[MODE_W*i +: MODE_W]),
         .lvl   (lvl[i])
      );
   end

endmodule

// File: tb/tb_pulse_lvl_conv.sv
// Self-checking bench for pulse_lvl_conv: directed scenarios then randomized traffic,
// compared each cycle against a timestamp-based behavioural model.
module tb_pulse_lvl_conv;
   import pulse_lvl_pkg::*;

   localparam int CH  = 4;
   localparam int SW  = 4;
   localparam int LEN = 8;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [CH-1:0]   d, clr, lvl;
   logic [2*CH-1:0] mode;

   int n_checks = 0;
   int n_err    = 0;

   // Reference model state: cycle index, toggle parity, time of last stretch trigger.
   int            cyc;
   logic [CH-1:0] exp_lvl;
   bit            tog[CH];
   int            last_st[CH];
   bit            pd[CH];
   logic [1:0]    pm[CH];

   pulse_lvl_conv #(
      .CH          (CH),
      .STRETCH_W   (SW),
      .STRETCH_LEN (LEN)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (d),
      .clr   (clr),
      .mode  (mode),
      .lvl   (lvl)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic void model_reset();
      for (int i = 0; i < CH; i++) begin
         tog[i]     = 1'b0;
         last_st[i] = -100000;
         pd[i]      = 1'b0;
         pm[i]      = 2'b00;
      end
      exp_lvl = '0;
   endfunction

   // Output for the cycle after 'cyc' given the inputs currently applied.
   function automatic void model_step();
      for (int i = 0; i < CH; i++) begin
         logic [1:0] m;
         bit e;
         m = mode[2*i +: 2];
         e = 1'b0;
         if (clr[i] || m != pm[i]) begin
            tog[i]     = 1'b0;
            last_st[i] = -100000;
         end else begin
            case (mode_e'(m))
               MODE_TOGGLE: begin
                  tog[i] = tog[i] ^ d[i];
                  e      = tog[i];
               end
               MODE_STRETCH: begin
                  if (d[i]) last_st[i] = cyc;
                  e = (cyc - last_st[i]) < LEN;
               end
               MODE_EDGE: e = (d[i] != pd[i]);
               default:   e = 1'b0;
            endcase
         end
         if (mode_e'(m) != MODE_TOGGLE) tog[i] = 1'b0;
         pd[i]      = d[i];
         pm[i]      = m;
         exp_lvl[i] = e;
      end
   endfunction

   task automatic step(input logic [CH-1:0] dv, input logic [CH-1:0] cv, input logic [2*CH-1:0] mv);
      d    = dv;
      clr  = cv;
      mode = mv;
      @(posedge clk);
      model_step();
      cyc++;
      #1;
      check("lvl_vs_model", lvl, exp_lvl);
   endtask

   // Asserted away from any clock edge so the async clear is observed without a clock.
   task automatic apply_reset();
      rst_n = 1'b0;
      #1;
      check("async_clear", lvl, '0);
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      logic [2*CH-1:0] mv, mv2, mr;
      logic [CH-1:0]   dv, cv;
      int              c;

      rst_n = 1'b1;
      d     = '0;
      clr   = '0;
      mode  = '0;
      cyc   = 0;
      #2;
      apply_reset();

      // ch0 TOGGLE, ch1 STRETCH, ch2 EDGE, ch3 RSVD
      mv = 8'b11_10_01_00;
      for (int k = 0; k < 22; k++) begin
         dv[0] = (k == 2) || (k == 3) || (k == 7);
         dv[1] = (k == 5) || (k == 10);
         dv[2] = (k >= 4) && (k <= 8);
         dv[3] = 1'($urandom);
         step(dv, '0, mv);
         c = k + 1;
         check("toggle_ch0", 32'(lvl[0]), 32'((c == 3) || (c >= 8)));
         check("stretch_ch1", 32'(lvl[1]), 32'((c >= 6) && (c <= 18)));
         check("edge_ch2", 32'(lvl[2]), 32'((c == 5) || (c == 10)));
         check("rsvd_ch3", 32'(lvl[3]), 32'd0);
      end

      step(4'b0001, 4'b0001, mv);
      check("clr_over_d", 32'(lvl[0]), 32'd0);
      step(4'b0001, 4'b0000, mv);
      check("toggle_after_clr", 32'(lvl[0]), 32'd1);

      mv2 = 8'b11_10_01_10;
      step(4'b0001, 4'b0000, mv2);
      check("mode_switch_clear", 32'(lvl[0]), 32'd0);
      for (int k = 0; k < 3; k++) begin
         step(4'b0001, 4'b0000, mv2);
         check("edge_no_pulse", 32'(lvl[0]), 32'd0);
      end
      step(4'b0000, 4'b0000, mv2);
      check("edge_fall_pulse", 32'(lvl[0]), 32'd1);

      step(4'b0010, 4'b0000, mv2);
      check("stretch_load", 32'(lvl[1]), 32'd1);
      for (int k = 0; k < 3; k++) step(4'b0000, 4'b0000, mv2);
      check("stretch_mid", 32'(lvl[1]), 32'd1);
      apply_reset();
      for (int k = 0; k < 4; k++) begin
         step(4'b0000, 4'b0000, mv2);
         check("post_reset_idle", lvl, '0);
      end

      mr = mv2;
      for (int k = 0; k < 300; k++) begin
         if (k == 150) apply_reset();
         for (int i = 0; i < CH; i++) begin
            if ($urandom_range(0, 19) == 0) mr[2*i +: 2] = 2'($urandom);
            dv[i] = ($urandom_range(0, 3) == 0);
            cv[i] = ($urandom_range(0, 15) == 0);
         end
         step(dv, cv, mr);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
